mag_comp_seq: RTL and testbench
===============================

MAG_COMP_SEQ -- requirements
Module: mag_comp_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits; even, >= 2.
REQ-002 SHALL have parameter: CHUNK, 2, bits compared per cycle; WIDTH % CHUNK == 0; NCH = WIDTH/CHUNK.
REQ-003 SHALL have port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port: a  input  WIDTH  operand A; sampled with accepted start.
REQ-007 SHALL have port: b  input  WIDTH  operand B; sampled with accepted start.
REQ-008 SHALL have port: busy  output  1  high while a comparison is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when a result is written.
REQ-010 SHALL have ports: G, L, E  output  1 each  registered result: A>B, A<B, A==B; one-hot once written.

Function
REQ-011 SHALL implement FSM states IDLE and CMP.
REQ-012 IDLE + start=1 at an edge: latch a, b, and sgn (if present); idx <= NCH-1; go to CMP; busy=1 from that edge.
REQ-013 IDLE + start=0: remain in IDLE; a, b ignored.
REQ-014 CMP: each edge compares chunk idx of the latched operands, bits [idx*CHUNK+CHUNK-1 : idx*CHUNK], MSB chunk first.
REQ-015 Chunks differ: write G=1,L=0,E=0 (A chunk greater) or G=0,L=1,E=0; done=1 for the next cycle; busy=0; go to IDLE.
REQ-016 Chunks equal and idx>0: idx <= idx-1; stay in CMP; outputs unchanged.
REQ-017 Chunks equal and idx==0: write G=0,L=0,E=1; done=1; busy=0; go to IDLE.
REQ-018 Latency: m edges from the start edge to the result edge, where m = 1 + (NCH-1 - index of the highest differing chunk); m = NCH when equal.
REQ-019 start while busy=1 SHALL be ignored: no relatch, no queueing.
REQ-020 start high in the cycle done is high SHALL be accepted, because the FSM is already in IDLE.
REQ-021 G/L/E SHALL hold their last written value until the next result edge, including while busy.
REQ-022 Changes on a/b after the start edge SHALL NOT affect the in-flight result.

Reset
REQ-023 rst=1 at an edge SHALL set state=IDLE, idx=0, busy=0, done=0, G=0, L=0, E=0.
REQ-024 rst during CMP SHALL abort the comparison: no done pulse, and the result is not written.
REQ-025 rst SHALL take priority over start in the same cycle.

Configuration
REQ-026 With COMP_SIGNED_EN defined: port sgn input 1 SHALL exist; with sgn latched as 1, operands SHALL compare as two's complement by inverting the operand MSB in chunk NCH-1 only.
REQ-027 Without COMP_SIGNED_EN: port sgn SHALL be absent and all comparisons SHALL be unsigned.

Structure
REQ-028 Package mag_comp_pkg SHALL hold the state typedef (IDLE, CMP) and the result-encoding localparams (RES_GT, RES_LT, RES_EQ).
REQ-029 Sub-module chunk_cmp (combinational, CHUNK-bit inputs, gt/lt outputs) SHALL perform the per-chunk compare; mag_comp_seq SHALL instantiate it once.

Verification (WIDTH=8, CHUNK=2)
REQ-030 a=8'hA5, b=8'hA5, start pulse -> busy for 4 cycles; then E=1, G=L=0, done pulse of one cycle.
REQ-031 a=8'h80, b=8'h7F unsigned -> G=1 on the first edge after start (m=1); with COMP_SIGNED_EN and sgn=1 -> L=1, m=1.
REQ-032 a=8'h34, b=8'h36 -> L=1 after m=4; a changed to 8'hFF mid-operation -> result unchanged.
REQ-033 start at cycle 0, second start at cycle 2 with a=8'h00, b=8'hFF -> second start ignored; first result only.
REQ-034 rst asserted at cycle 2 of an equal-operand compare -> no done; G=L=E=0; busy=0 the next cycle.
REQ-035 start held high across a done cycle with new operands 8'h01/8'h02 -> second comparison accepted back-to-back; L=1 after 4 more edges.

Source files
------------

// File: rtl/mag_comp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state encoding and
// the {G,L,E} result words written by mag_comp_seq.
package mag_comp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // Result words are packed as {G, L, E}.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;

endpackage

// File: rtl/mag_comp_seq_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module chunk_cmp #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/mag_comp_seq.sv
// Sequential magnitude comparator: walks the latched operands MSB chunk first and
// stops at the first differing chunk. Signed mode is built in with `define COMP_SIGNED_EN.
module mag_comp_seq
    import mag_comp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef COMP_SIGNED_EN
    input  logic             sgn,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             L,
    output logic             E,
    output logic             dbg_state
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NCH - 1);

    // Handshake: start is a request taken only while busy is low (FSM in IDLE);
    // the edge that takes it latches a/b and raises busy. busy drops on the
    // result edge, when done pulses for exactly one cycle with G/L/E updated.
    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       res, res_n;
    logic             done_n;
    logic             load;
    logic [CHUNK-1:0] ca, cb;
    logic             c_gt, c_lt;
`ifdef COMP_SIGNED_EN
    logic             sgn_q;
`endif

    always_comb begin
        ca = a_q[idx*CHUNK +: CHUNK];
        cb = b_q[idx*CHUNK +: CHUNK];
`ifdef COMP_SIGNED_EN
        // Flipping only the sign bit maps two's complement onto unsigned order.
        if (sgn_q && (idx == IDX_TOP)) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
`endif
    end

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a  (ca),
        .b  (cb),
        .gt (c_gt),
        .lt (c_lt)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        res_n   = res;
        done_n  = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_n   = IDX_TOP;
                    state_n = CMP;
                end
            end
            CMP: begin
                if (c_gt) begin
                    res_n   = RES_GT;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (c_lt) begin
                    res_n   = RES_LT;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (idx == '0) begin
                    res_n   = RES_EQ;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    idx_n = idx - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            res   <= RES_NONE;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            res   <= res_n;
            done  <= done_n;
        end
    end

    // Operand registers need no reset: they are only read after a load.
    always_ff @(posedge clk) begin
        if (!rst && load) begin
            a_q <= a;
            b_q <= b;
`ifdef COMP_SIGNED_EN
            sgn_q <= sgn;
`endif
        end
    end

    assign busy      = (state == CMP);
    assign dbg_state = (state == CMP);
    assign G         = res[2];
    assign L         = res[1];
    assign E         = res[0];

endmodule

// File: tb/tb_mag_comp_seq.sv
// Self-checking bench for mag_comp_seq (WIDTH=8, CHUNK=2): directed cases plus
// randomized comparisons scored against an arithmetic reference model.
module tb_mag_comp_seq;

  localparam int WIDTH = 8;
  localparam int CHUNK = 2;
  localparam int NCH   = WIDTH / CHUNK;
  localparam int W     = 8;
`ifdef COMP_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, G, L, E, dbg_state;
`ifdef COMP_SIGNED_EN
  logic             sgn;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];
  logic [2:0]   prev_res;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mag_comp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef COMP_SIGNED_EN
    .sgn       (sgn),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .G         (G),
    .L         (L),
    .E         (E),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected word {G,L,E, latency[4:0]} from plain arithmetic on the operands.
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                         input logic s);
    logic [2:0]       r;
    logic [WIDTH-1:0] d;
    int               m;
    if (s && SIGNED_BUILD)
      r = ($signed(x) > $signed(y)) ? 3'b100 : ($signed(x) < $signed(y)) ? 3'b010 : 3'b001;
    else
      r = (x > y) ? 3'b100 : (x < y) ? 3'b010 : 3'b001;
    d = x ^ y;
    m = NCH;
    for (int i = 0; i < WIDTH; i++)
      if (d[i]) m = NCH - i / CHUNK;
    return {r, 5'(m)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s, input logic hold);
    a = x;
    b = y;
`ifdef COMP_SIGNED_EN
    sgn = s;
`endif
    start = 1'b1;
    exp_q.push_back(model(x, y, s));
    @(posedge clk); #1;
    check("busy_on_start", 32'(busy), 32'(1));
    check("state_on_start", 32'(dbg_state), 32'(1));
    check("done_on_start", 32'(done), 32'(0));
    start = hold;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic finish_cmp(input logic hold, input logic linger);
    logic [W-1:0] e;
    int           k;
    logic         got;
    e   = exp_q.pop_front();
    k   = 1;
    got = 1'b0;
    while (!got && k <= NCH + 3) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
      else begin
        check("busy_mid", 32'(busy), 32'(1));
        check("held_mid", 32'({G, L, E}), 32'(prev_res));
        start = hold;
        a = 8'($urandom);
        b = 8'($urandom);
        k++;
      end
    end
    check("done_seen", 32'(got), 32'(1));
    check("latency", 32'(k), 32'(e[4:0]));
    check("result", 32'({G, L, E}), 32'(e[7:5]));
    check("busy_after", 32'(busy), 32'(0));
    prev_res = e[7:5];
    if (linger) begin
      start = 1'b0;
      @(posedge clk); #1;
      check("done_pulse", 32'(done), 32'(0));
      check("held_idle", 32'({G, L, E}), 32'(prev_res));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] x, y;
    logic             seen;
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
`ifdef COMP_SIGNED_EN
    sgn   = 1'b0;
`endif
    prev_res = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_gle", 32'({G, L, E}), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(0));
    rst   = 1'b0;
    start = 1'b0;

    launch(8'hA5, 8'hA5, 1'b0, 1'b0);  finish_cmp(1'b0, 1'b1);
    launch(8'h80, 8'h7F, 1'b0, 1'b0);  finish_cmp(1'b0, 1'b1);
`ifdef COMP_SIGNED_EN
    launch(8'h80, 8'h7F, 1'b1, 1'b0);  finish_cmp(1'b0, 1'b1);
`endif
    launch(8'h34, 8'h36, 1'b0, 1'b0);  finish_cmp(1'b0, 1'b1);
    // start held high for the whole run must not relatch
    launch(8'h12, 8'h12, 1'b0, 1'b1);  finish_cmp(1'b1, 1'b1);
    // back-to-back: start high during the done cycle
    launch(8'hA5, 8'hA5, 1'b0, 1'b0);  finish_cmp(1'b0, 1'b0);
    launch(8'h01, 8'h02, 1'b0, 1'b0);  finish_cmp(1'b0, 1'b1);

    // reset in the middle of an equal-operand compare, with start also high
    launch(8'h5A, 8'h5A, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_gle", 32'({G, L, E}), 32'(0));
    rst   = 1'b0;
    start = 1'b0;
    void'(exp_q.pop_front());
    prev_res = 3'b000;
    seen = 1'b0;
    repeat (NCH + 2) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'(0));
    check("abort_gle_hold", 32'({G, L, E}), 32'(0));

    for (int n = 0; n < 40; n++) begin
      x = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       y = x;
        1:       y = x ^ (8'($urandom) >> $urandom_range(0, 7));
        default: y = 8'($urandom);
      endcase
      launch(x, y, 1'($urandom), 1'($urandom_range(0, 3) == 0));
      finish_cmp(1'($urandom_range(0, 3) == 0), (n == 39) ? 1'b1 : 1'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
